// File: rtl/result_collector_if.sv
// result_collector_if
//   Bundles the array drain side (per-column result words and strobes) and the
//   host read port of the result collector.
//   master : drives data_in/valid_in and rd_en/rd_addr, receives rd_data/rd_valid
//   slave  : the collector itself
interface result_collector_if #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
);
  localparam int NUM_WORDS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_in;
  logic [MATRIX_SIZE-1:0]                valid_in;
  logic                                  rd_en;
  logic [ADDR_W-1:0]                     rd_addr;
  logic [DATA_SIZE-1:0]                  rd_data;
  logic                                  rd_valid;

  modport master (
    output data_in, valid_in, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  data_in, valid_in, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/result_collector.sv
// result_collector
//   Captures the per-column results draining from the bottom of a
//   MATRIX_SIZE x MATRIX_SIZE systolic array into a row-major result memory,
//   flags completion when every column has delivered MATRIX_SIZE words, and
//   offers a registered read port for unloading the matrix.
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   enable   : run qualifier; low returns to IDLE and clears counters/overflow
//   bus      : drain strobes/data and read port (slave modport)
//   busy     : high in COLLECT
//   done     : high in DONE
//   overflow : sticky, a strobe arrived for an already full column
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for enable; strobes ignored
// COLLECT | columns write results independently as their strobes arrive
// DONE    | every column full; any strobe flags overflow, nothing written
module result_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  result_collector_if.slave        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int NUM_WORDS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W     = $clog2(MATRIX_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MATRIX_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q [MATRIX_SIZE];
  logic [CNT_W-1:0]     cnt_d [MATRIX_SIZE];
  logic [DATA_SIZE-1:0] mem_q [NUM_WORDS];
  logic [DATA_SIZE-1:0] mem_d [NUM_WORDS];
  logic                 overflow_q, overflow_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 all_full;

  // Row-major location of the next result of a column: row*MATRIX_SIZE+col.
  function automatic logic [ADDR_W-1:0] wr_addr(input logic [CNT_W-1:0] row, input int col);
    return ADDR_W'(int'(row) * MATRIX_SIZE + col);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    all_full   = 1'b1;

    // Read uses mem_q, so a same-edge write to the same address reads old data.
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      if (int'(bus.rd_addr) < NUM_WORDS) begin
        rd_data_d = mem_q[bus.rd_addr];
      end else begin
        rd_data_d = '0;
      end
    end

    unique case (state_q)
      IDLE: begin
        state_d = COLLECT;
      end
      COLLECT: begin
        // Each column advances on its own strobe, absorbing array skew.
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          if (bus.valid_in[j]) begin
            if (cnt_q[j] != CNT_FULL) begin
              mem_d[wr_addr(cnt_q[j], j)] = bus.data_in[j];
              cnt_d[j] = cnt_q[j] + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          if (cnt_d[j] != CNT_FULL) begin
            all_full = 1'b0;
          end
        end
        if (all_full) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (|bus.valid_in) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping enable aborts collection but keeps the memory readable.
    if (!enable) begin
      state_d    = IDLE;
      overflow_d = 1'b0;
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        cnt_d[j] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        cnt_q[j] <= '0;
      end
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign busy         = (state_q == COLLECT);
  assign done         = (state_q == DONE);
  assign overflow     = overflow_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector
//   Directed bench for result_collector with MATRIX_SIZE=2, DATA_SIZE=32.
//   A vector table covers the aligned drain, read-out, overflow, enable-low
//   clear and a skewed drain; hand-written sequences cover IDLE strobes,
//   read/write collision and asynchronous reset mid-collection.
module tb_result_collector;
  localparam int MS = 2;
  localparam int DS = 32;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;
  logic busy, done, overflow;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_collector_if #(.MATRIX_SIZE(MS), .DATA_SIZE(DS)) bus ();

  result_collector #(.MATRIX_SIZE(MS), .DATA_SIZE(DS)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  typedef struct {
    logic        en;
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rd_en;
    logic [1:0]  addr;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_busy;
    logic        e_done;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [1:0] valid, input logic [31:0] d0,
                              input logic [31:0] d1, input logic rd_en, input logic [1:0] addr,
                              input logic e_rv, input logic [31:0] e_rd, input logic e_busy,
                              input logic e_done, input logic e_ov);
    vec_t v;
    v.en = en; v.valid = valid; v.d0 = d0; v.d1 = d1; v.rd_en = rd_en; v.addr = addr;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_busy = e_busy; v.e_done = e_done; v.e_ov = e_ov;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] valid, input logic [31:0] d0,
                       input logic [31:0] d1, input logic rd_en, input logic [1:0] addr);
    enable          = en;
    bus.valid_in    = valid;
    bus.data_in[0]  = d0;
    bus.data_in[1]  = d1;
    bus.rd_en       = rd_en;
    bus.rd_addr     = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_rd,
                         input logic e_busy, input logic e_done, input logic e_ov);
    chk({tag, " rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, e_rv});
    chk({tag, " rd_data"},  bus.rd_data,           e_rd);
    chk({tag, " busy"},     {31'd0, busy},         {31'd0, e_busy});
    chk({tag, " done"},     {31'd0, done},         {31'd0, e_done});
    chk({tag, " overflow"}, {31'd0, overflow},     {31'd0, e_ov});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    //   en valid d0  d1  rd addr | rv  rd   busy done ov
    // aligned drain
    add(1, 2'b00,  0,  0, 0, 0,     0,  0,   1,   0,   0);
    add(1, 2'b11,  1,  3, 0, 0,     0,  0,   1,   0,   0);
    add(1, 2'b11,  2,  4, 0, 0,     0,  0,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 0,     1,  1,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 1,     1,  3,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 2,     1,  2,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 3,     1,  4,   0,   1,   0);
    add(1, 2'b00,  0,  0, 0, 0,     0,  4,   0,   1,   0);
    // overflow after done, sticky, memory untouched
    add(1, 2'b01, 55,  0, 0, 0,     0,  4,   0,   1,   1);
    add(1, 2'b00,  0,  0, 0, 0,     0,  4,   0,   1,   1);
    add(1, 2'b00,  0,  0, 1, 0,     1,  1,   0,   1,   1);
    // enable low clears overflow, returns to IDLE, memory retained
    add(0, 2'b00,  0,  0, 1, 3,     1,  4,   0,   0,   0);
    add(0, 2'b11, 98, 99, 1, 0,     1,  1,   0,   0,   0);
    add(1, 2'b00,  0,  0, 1, 2,     1,  2,   1,   0,   0);
    add(1, 2'b00,  0,  0, 0, 0,     0,  2,   1,   0,   0);
    // skewed drain
    add(1, 2'b01,  7,  0, 0, 0,     0,  2,   1,   0,   0);
    add(1, 2'b11,  8,  9, 0, 0,     0,  2,   1,   0,   0);
    add(1, 2'b10,  0, 10, 0, 0,     0,  2,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 0,     1,  7,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 1,     1,  9,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 2,     1,  8,   0,   1,   0);
    add(1, 2'b00,  0,  0, 1, 3,     1, 10,   0,   1,   0);

    drive(0, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].rd_en, vecs[i].addr);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_rd,
              vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ov);
    end

    // Reset clears memory; strobes in IDLE are ignored.
    drive(0, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(0, 2'b11, 5, 6, 0, 0);
    tick();
    chk_all("idle_strobe0", 0, 0, 0, 0, 0);
    tick();
    chk_all("idle_strobe1", 0, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0);
    tick();
    chk_all("idle_enable", 0, 0, 1, 0, 0);
    drive(1, 2'b00, 0, 0, 1, 0);
    tick();
    chk_all("idle_mem0", 1, 0, 1, 0, 0);

    // Collision: col1 row0 (addr 1) written while addr 1 is read.
    drive(1, 2'b10, 0, 42, 1, 1);
    tick();
    chk_all("collide_old", 1, 0, 1, 0, 0);
    drive(1, 2'b00, 0, 0, 1, 1);
    tick();
    chk_all("collide_new", 1, 42, 1, 0, 0);

    // Fill col1, overflow it, then async reset between edges.
    drive(1, 2'b10, 0, 43, 0, 0);
    tick();
    chk_all("col1_full", 0, 42, 1, 0, 0);
    drive(1, 2'b10, 0, 44, 0, 0);
    tick();
    chk_all("col1_ovf", 0, 42, 1, 0, 1);
    drive(1, 2'b00, 0, 0, 1, 3);
    tick();
    chk_all("col1_read", 1, 43, 1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst_collect", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 2'b00, 0, 0, 1, 0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      tick();
      chk_all($sformatf("post_rst_rd%0d", a), 1, 0, 0, 0, 0);
    end

    // Async reset while in DONE drops done immediately.
    drive(1, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 2'b11, 21, 22, 0, 0);
    tick();
    drive(1, 2'b11, 23, 24, 0, 0);
    tick();
    chk_all("done_again", 0, 0, 0, 1, 0);
    drive(1, 2'b00, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst_done", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Drain-side counterpart of the systolic array's operand fetcher.
- Captures the per-column results leaving the bottom edge of the MATRIX_SIZE x MATRIX_SIZE array. Each column delivers its results with its own skew and valid strobe.
- Writes each result into a row-major result memory and flags completion once every column has delivered MATRIX_SIZE results.
- Exposes a registered read port so the host or testbench can unload the result matrix.

Parameters:
- MATRIX_SIZE, 2, array dimension; results per column and number of columns.
- DATA_SIZE, 32, width of one result word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  run qualifier; low synchronously clears the collection state.
- data_in  input  [DATA_SIZE-1:0] x MATRIX_SIZE  result word per array column.
- valid_in  input  MATRIX_SIZE  per-column strobe; bit j qualifies data_in[j].
- rd_en  input  1  read request.
- rd_addr  input  $clog2(MATRIX_SIZE*MATRIX_SIZE) (min 1)  row-major address, row*MATRIX_SIZE+col.
- rd_data  output  [DATA_SIZE-1:0]  read data.
- rd_valid  output  1  rd_data valid this cycle.
- busy  output  1  high in COLLECT.
- done  output  1  high in DONE.
- overflow  output  1  sticky error; a strobe arrived for a full column.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; per-column row counters=0.
  - busy=0, done=0, overflow=0, rd_valid=0, rd_data=0.
  - Result memory is cleared to 0.
- enable=0 (sync, reset=1):
  - state=IDLE; counters=0; overflow=0.
  - Memory contents are retained.
  - The read port keeps operating.
- States:
  - IDLE -> COLLECT on the first clk edge with enable=1. Strobes in IDLE are ignored and not counted.
  - COLLECT: for each j with valid_in[j]=1 and cnt[j]<MATRIX_SIZE, write data_in[j] to mem[cnt[j]*MATRIX_SIZE+j] and increment cnt[j].
  - COLLECT: if valid_in[j]=1 and cnt[j]==MATRIX_SIZE, drop the word and set overflow.
  - COLLECT -> DONE on the edge after which all cnt[j]==MATRIX_SIZE. done rises the cycle after the final write.
  - DONE: holds until enable=0. Any valid_in bit in DONE sets overflow and does not write.
- Simultaneous strobes: any subset of columns may write in the same cycle; the addresses are always distinct. Columns progress independently, so skew is absorbed.
- Counters: width $clog2(MATRIX_SIZE+1); they saturate at MATRIX_SIZE and never wrap.
- Read port:
  - Usable in every state.
  - rd_en at edge N -> rd_data=mem[rd_addr] and rd_valid=1 after edge N.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
  - rd_addr >= MATRIX_SIZE^2 returns 0 with rd_valid=1.
- Read/write same address, same edge: the read returns the old value (read-before-write).
- Reset mid-COLLECT: everything returns to reset values immediately; partial results are lost.

Test Plan:
- Aligned drain, MATRIX_SIZE=2:
  - Stimulus: reset, enable=1; cycle k: valid_in=2'b11, data_in={3,1}; cycle k+1: valid_in=2'b11, data_in={4,2}.
  - Response: done=1 one cycle after k+1; reads of addresses 0..3 return 1,3,2,4 with rd_valid one cycle after each rd_en.
- Skewed drain:
  - Stimulus: col0 strobes at cycles 2,3 (values 7,8); col1 strobes at cycles 3,4 (values 9,10).
  - Response: done rises after cycle 4 only; memory reads 7,9,8,10; busy=1 from cycle 1 until done.
- Overflow:
  - Stimulus: after done, pulse valid_in[0] with data 55.
  - Response: overflow=1 and sticky; mem[0] unchanged; enable=0 for one cycle clears overflow, state returns to IDLE, memory is retained.
- IDLE ignore:
  - Stimulus: strobes with enable=0, then enable=1 with no strobes.
  - Response: counters stay 0, done stays 0, memory stays 0.
- Async reset mid-collect:
  - Stimulus: one column filled, then reset=0 between clock edges.
  - Response: busy, done, overflow and rd_valid drop immediately; after release, all memory reads return 0.
- Read/write collision:
  - Stimulus: rd_en with rd_addr=1 in the same cycle col1 writes row 0 with value 42.
  - Response: rd_data returns the prior value (0); the next read returns 42.
